// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer control path: state encoding, BCD
// constants and the single-digit BCD decrement used by the countdown.
package egg_timer_pkg;

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_SETTING = 2'd1;
  localparam logic [1:0] ST_RUNNING = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    S_INIT    = ST_INIT,
    S_SETTING = ST_SETTING,
    S_RUNNING = ST_RUNNING,
    S_DONE    = ST_DONE
  } state_e;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_FIVE = 4'd5;
  localparam logic [3:0] BCD_NINE = 4'd9;

  localparam logic [3:0] DEFAULT_MAX_SEC_TENS = 4'd5;

  // Decrement one digit, wrapping to the given value on borrow.
  function automatic logic [3:0] bcd_dec(input logic [3:0] digit, input logic [3:0] wrap);
    return (digit == BCD_ZERO) ? wrap : (digit - 4'd1);
  endfunction

endpackage

// File: rtl/bcd_mmss_down_counter.sv
// MM:SS BCD down counter with clear, parallel load and one-second decrement.
// Digit order in load_value is {min tens, min ones, sec tens, sec ones}.
module bcd_mmss_down_counter
  import egg_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        dec,
  input  logic        clr,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        is_zero_next
);

  logic [15:0] count_q, count_d;
  logic [15:0] dec_value;
  logic        borrow0, borrow1, borrow2;

  // Borrow chain for the decremented value; seconds tens wraps to five.
  always_comb begin
    borrow0 = (count_q[3:0] == BCD_ZERO);
    borrow1 = borrow0 && (count_q[7:4] == BCD_ZERO);
    borrow2 = borrow1 && (count_q[11:8] == BCD_ZERO);
    dec_value[3:0]   = bcd_dec(count_q[3:0], BCD_NINE);
    dec_value[7:4]   = borrow0 ? bcd_dec(count_q[7:4], BCD_FIVE) : count_q[7:4];
    dec_value[11:8]  = borrow1 ? bcd_dec(count_q[11:8], BCD_NINE) : count_q[11:8];
    dec_value[15:12] = borrow2 ? (count_q[15:12] - 4'd1) : count_q[15:12];
  end

  // Next count: clear beats load beats decrement; 00:00 never wraps.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 16'h0000;
    end else if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != 16'h0000)) begin
      count_d = dec_value;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign digit0       = count_q[3:0];
  assign digit1       = count_q[7:4];
  assign digit2       = count_q[11:8];
  assign digit3       = count_q[15:12];
  assign is_zero_next = (count_q == 16'h0001);

endmodule

// File: rtl/egg_timer_control.sv
// Egg timer control FSM: captures the keyed MM:SS setting, drives the BCD
// countdown and produces registered state flags, alarm and display digits.
module egg_timer_control
  import egg_timer_pkg::*;
#(
  parameter logic [3:0] MAX_SEC_TENS = DEFAULT_MAX_SEC_TENS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       clear,
  output logic [3:0] setting0,
  output logic [3:0] setting1,
  output logic [3:0] setting2,
  output logic [3:0] setting3,
  output logic [3:0] running0,
  output logic [3:0] running1,
  output logic [3:0] running2,
  output logic [3:0] running3,
  output logic       isInit,
  output logic       isSetting,
  output logic       isRunning,
  output logic       alarm
);

  state_e      state_q, state_d;
  logic [15:0] setting_q, setting_d;
  logic        is_init_q, is_init_d;
  logic        is_setting_q, is_setting_d;
  logic        is_running_q, is_running_d;
  logic        alarm_q, alarm_d;
  logic        cnt_load, cnt_dec, cnt_clr, cnt_zero_next;
  logic        start_ok;

  assign start_ok = (setting_q[7:4] <= MAX_SEC_TENS) && (setting_q != 16'h0000);

  // Next state and setting; only the highest-priority event of a cycle acts.
  always_comb begin
    state_d   = state_q;
    setting_d = setting_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clr   = 1'b0;
    if (clear) begin
      state_d   = S_INIT;
      setting_d = 16'h0000;
      cnt_clr   = 1'b1;
    end else if (start) begin
      if (((state_q == S_SETTING) || (state_q == S_DONE)) && start_ok) begin
        state_d  = S_RUNNING;
        cnt_load = 1'b1;
      end else begin
        state_d = state_q;
      end
    end else if (key_valid) begin
      if (key_digit <= BCD_NINE) begin
        case (state_q)
          S_INIT, S_DONE: begin
            setting_d = {12'h000, key_digit};
            state_d   = S_SETTING;
          end
          S_SETTING: setting_d = {setting_q[11:0], key_digit};
          default:   setting_d = setting_q;
        endcase
      end else begin
        setting_d = setting_q;
      end
    end else if (tick_1hz && (state_q == S_RUNNING)) begin
      cnt_dec = 1'b1;
      if (cnt_zero_next) begin
        state_d = S_DONE;
      end else begin
        state_d = S_RUNNING;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Flags are decoded from the next state so they register alongside it.
  always_comb begin
    is_init_d    = (state_d == S_INIT);
    is_setting_d = (state_d == S_SETTING);
    is_running_d = (state_d == S_RUNNING);
    alarm_d      = (state_d == S_DONE);
  end

  // State, setting and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      setting_q    <= 16'h0000;
      is_init_q    <= 1'b1;
      is_setting_q <= 1'b0;
      is_running_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      setting_q    <= setting_d;
      is_init_q    <= is_init_d;
      is_setting_q <= is_setting_d;
      is_running_q <= is_running_d;
      alarm_q      <= alarm_d;
    end
  end

  bcd_mmss_down_counter u_counter (
    .clk          (clk),
    .reset        (reset),
    .load         (cnt_load),
    .load_value   (setting_q),
    .dec          (cnt_dec),
    .clr          (cnt_clr),
    .digit0       (running0),
    .digit1       (running1),
    .digit2       (running2),
    .digit3       (running3),
    .is_zero_next (cnt_zero_next)
  );

  assign setting0  = setting_q[3:0];
  assign setting1  = setting_q[7:4];
  assign setting2  = setting_q[11:8];
  assign setting3  = setting_q[15:12];
  assign isInit    = is_init_q;
  assign isSetting = is_setting_q;
  assign isRunning = is_running_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_egg_timer_control.sv
// Scoreboard bench for egg_timer_control: directed vectors push expected
// snapshots; a negedge monitor pops and compares them against the outputs.
module tb_egg_timer_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] setting0, setting1, setting2, setting3;
  logic [3:0] running0, running1, running2, running3;
  logic       isInit, isSetting, isRunning, alarm;

  always #5 clk = ~clk;

  egg_timer_control dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .key_valid(key_valid),
    .key_digit(key_digit), .start(start), .clear(clear),
    .setting0(setting0), .setting1(setting1), .setting2(setting2), .setting3(setting3),
    .running0(running0), .running1(running1), .running2(running2), .running3(running3),
    .isInit(isInit), .isSetting(isSetting), .isRunning(isRunning), .alarm(alarm)
  );

  typedef struct packed {
    logic [2:0]  flags;
    logic        alarm;
    logic [15:0] setting;
    logic [15:0] running;
  } snap_t;

  localparam logic [2:0] F_INIT = 3'b100;
  localparam logic [2:0] F_SET  = 3'b010;
  localparam logic [2:0] F_RUN  = 3'b001;
  localparam logic [2:0] F_NONE = 3'b000;

  snap_t exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic expect_snap(input string nm, input logic [2:0] fl, input logic al,
                             input logic [15:0] s, input logic [15:0] r);
    snap_t e;
    e.flags = fl; e.alarm = al; e.setting = s; e.running = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare one pending expectation per cycle, away from the clock edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.flags   = {isInit, isSetting, isRunning};
      a.alarm   = alarm;
      a.setting = {setting3, setting2, setting1, setting0};
      a.running = {running3, running2, running1, running0};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got flags=%b alarm=%b set=%h run=%h, want flags=%b alarm=%b set=%h run=%h",
                 nm, a.flags, a.alarm, a.setting, a.running, e.flags, e.alarm, e.setting, e.running);
      end
    end
  end

  task automatic drv(input logic tk, input logic kv, input logic [3:0] kd,
                     input logic st, input logic cl);
    @(negedge clk);
    tick_1hz = tk; key_valid = kv; key_digit = kd; start = st; clear = cl;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    drv(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic tick();
    drv(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic go();
    drv(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_snap("reset", F_INIT, 1'b0, 16'h0000, 16'h0000);

    key(4'd1); key(4'd3); key(4'd0);
    expect_snap("keys_130", F_SET, 1'b0, 16'h0130, 16'h0000);
    key(4'd12);
    expect_snap("illegal_key", F_SET, 1'b0, 16'h0130, 16'h0000);

    key(4'd9); key(4'd9); key(4'd5); key(4'd9); key(4'd1);
    expect_snap("shift_out", F_SET, 1'b0, 16'h9591, 16'h0000);
    go();
    expect_snap("start_bad_sec_tens", F_SET, 1'b0, 16'h9591, 16'h0000);

    drv(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    expect_snap("clear_setting", F_INIT, 1'b0, 16'h0000, 16'h0000);
    key(4'd1); key(4'd0); key(4'd0);
    go();
    expect_snap("start_0100", F_RUN, 1'b0, 16'h0100, 16'h0100);
    tick();
    expect_snap("first_tick", F_RUN, 1'b0, 16'h0100, 16'h0059);
    for (int i = 0; i < 58; i++) tick();
    expect_snap("at_0001", F_RUN, 1'b0, 16'h0100, 16'h0001);
    tick();
    expect_snap("done", F_NONE, 1'b1, 16'h0100, 16'h0000);
    tick();
    expect_snap("tick_in_done", F_NONE, 1'b1, 16'h0100, 16'h0000);

    go();
    expect_snap("restart_done", F_RUN, 1'b0, 16'h0100, 16'h0100);
    for (int i = 0; i < 18; i++) tick();
    expect_snap("at_0042", F_RUN, 1'b0, 16'h0100, 16'h0042);
    drv(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    expect_snap("clear_tick", F_INIT, 1'b0, 16'h0000, 16'h0000);

    key(4'd5);
    expect_snap("init_load_key", F_SET, 1'b0, 16'h0005, 16'h0000);
    drv(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    expect_snap("start_tick", F_RUN, 1'b0, 16'h0005, 16'h0005);
    tick();
    expect_snap("after_start_tick", F_RUN, 1'b0, 16'h0005, 16'h0004);
    drv(1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
    expect_snap("clear_start_key", F_INIT, 1'b0, 16'h0000, 16'h0000);

    go();
    expect_snap("start_in_init", F_INIT, 1'b0, 16'h0000, 16'h0000);
    key(4'd0);
    go();
    expect_snap("start_zero_setting", F_SET, 1'b0, 16'h0000, 16'h0000);
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    go();
    expect_snap("start_1000", F_RUN, 1'b0, 16'h1000, 16'h1000);
    key(4'd3);
    expect_snap("key_in_running", F_RUN, 1'b0, 16'h1000, 16'h1000);
    tick();
    expect_snap("borrow_0959", F_RUN, 1'b0, 16'h1000, 16'h0959);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_snap("reset_mid_run", F_INIT, 1'b0, 16'h0000, 16'h0000);
    tick();
    expect_snap("tick_after_reset", F_INIT, 1'b0, 16'h0000, 16'h0000);

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
